// File: rtl/cti_pkg.sv
// Shared types and constants for the commit-side CTI update path.
// Record layout and control-transfer type encodings.
package cti_pkg;

    localparam int CTI_COMMIT_WIDTH = 4;

    localparam logic [6:0] CTI_BRANCH = 7'h01;
    localparam logic [6:0] CTI_JAL    = 7'h02;
    localparam logic [6:0] CTI_JALR   = 7'h04;
    localparam logic [6:0] CTI_CALL   = 7'h08;
    localparam logic [6:0] CTI_RET    = 7'h10;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic [6:0]  ctrl_type;
    } cti_update_t;

endpackage

// File: rtl/cti_lane_compact.sv
// Lane compaction for sparse commit groups: prefix offsets,
// total valid count and a free-space-clamped accept mask.
module cti_lane_compact
    import cti_pkg::*;
#(
    parameter int INDEX = 4
) (
    input  logic [CTI_COMMIT_WIDTH-1:0]      commit_valid,
    input  logic [INDEX:0]                   free,
    output logic [CTI_COMMIT_WIDTH-1:0][1:0] offset,
    output logic [CTI_COMMIT_WIDTH-1:0]      accept,
    output logic [2:0]                       n_total,
    output logic [2:0]                       n_accepted
);

    logic [2:0] cnt;
    logic [2:0] acc;

    always_comb begin
        cnt    = '0;
        acc    = '0;
        offset = '0;
        accept = '0;
        for (int k = 0; k < CTI_COMMIT_WIDTH; k++) begin
            offset[k] = cnt[1:0];
            // Earlier lanes win when the group does not fit.
            if (commit_valid[k] && ({{(INDEX-2){1'b0}}, cnt} < free)) begin
                accept[k] = 1'b1;
                acc       = acc + 3'd1;
            end
            if (commit_valid[k]) begin
                cnt = cnt + 3'd1;
            end
        end
        n_total    = cnt;
        n_accepted = acc;
    end

endmodule

// File: rtl/cti_update_queue.sv
// Circular queue packing committed CTI records for in-order,
// one-per-cycle drain to the branch predictor update port.
module cti_update_queue
    import cti_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int INDEX = 4,
    parameter int WIDTH = $bits(cti_update_t)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [CTI_COMMIT_WIDTH-1:0]       commit_valid_i,
    input  logic [CTI_COMMIT_WIDTH*WIDTH-1:0] commit_data_i,
    output logic                              stall_o,
    output logic                              upd_valid_o,
    output logic [WIDTH-1:0]                  upd_data_o,
    input  logic                              upd_ready_i,
    output logic [INDEX:0]                    count_o,
    output logic                              overflow_o
);

    logic [INDEX-1:0] head;
    logic [INDEX-1:0] tail;
    logic [INDEX:0]   count;
    logic             overflow;
    logic [WIDTH-1:0] mem [DEPTH];

    logic [INDEX:0]                   free;
    logic [CTI_COMMIT_WIDTH-1:0][1:0] offset;
    logic [CTI_COMMIT_WIDTH-1:0]      accept;
    logic [2:0]                       n_total;
    logic [2:0]                       n_accepted;
    logic                             deq;

    assign free = (INDEX+1)'(DEPTH) - count;
    assign deq  = (count != '0) && upd_ready_i;

    cti_lane_compact #(
        .INDEX(INDEX)
    ) u_compact (
        .commit_valid(commit_valid_i),
        .free        (free),
        .offset      (offset),
        .accept      (accept),
        .n_total     (n_total),
        .n_accepted  (n_accepted)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            tail  <= tail + INDEX'(n_accepted);
            head  <= head + INDEX'(deq);
            count <= count + (INDEX+1)'(n_accepted) - (INDEX+1)'(deq);
            if (n_total != n_accepted) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; empty slots are masked at the output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < CTI_COMMIT_WIDTH; k++) begin
                if (accept[k]) begin
                    mem[tail + INDEX'(offset[k])] <= commit_data_i[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign stall_o     = free < (INDEX+1)'(CTI_COMMIT_WIDTH);
    assign upd_valid_o = count != '0;
    assign upd_data_o  = upd_valid_o ? mem[head] : '0;
    assign count_o     = count;
    assign overflow_o  = overflow;

endmodule

// File: tb/tb_cti_update_queue.sv
// Self-checking bench for cti_update_queue: directed scenarios plus
// random traffic against a queue-based reference model.
module tb_cti_update_queue;

    localparam int W = 72;
    localparam int D = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     cv;
    logic [4*W-1:0] cd;
    logic           rdy;
    logic           stall_o;
    logic           upd_valid_o;
    logic [W-1:0]   upd_data_o;
    logic [4:0]     count_o;
    logic           overflow_o;

    always #5 clk = ~clk;

    cti_update_queue dut (
        .clk           (clk),
        .reset         (reset),
        .commit_valid_i(cv),
        .commit_data_i (cd),
        .stall_o       (stall_o),
        .upd_valid_o   (upd_valid_o),
        .upd_data_o    (upd_data_o),
        .upd_ready_i   (rdy),
        .count_o       (count_o),
        .overflow_o    (overflow_o)
    );

    logic [W-1:0] mq [$];
    bit           movf;
    int           n_pass = 0;
    int           n_fail = 0;
    int           n_total = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, ".count"}, W'(count_o), W'(sz));
        chk({tag, ".valid"}, W'(upd_valid_o), W'(sz != 0));
        chk({tag, ".stall"}, W'(stall_o), W'((D - sz) < 4));
        chk({tag, ".ovf"}, W'(overflow_o), W'(movf));
        chk({tag, ".data"}, upd_data_o, (sz != 0) ? mq[0] : '0);
    endtask

    function automatic logic [W-1:0] rnd_rec();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    function automatic logic [4*W-1:0] rnd_grp();
        logic [4*W-1:0] r;
        for (int k = 0; k < 4; k++) r[k*W +: W] = rnd_rec();
        return r;
    endfunction

    // One clock: check state-derived outputs, clock, then advance the model.
    task automatic cycle(input string tag, input logic [3:0] v,
                         input logic [4*W-1:0] d, input logic r);
        int free;
        cv = v;
        cd = d;
        rdy = r;
        reset = 1'b0;
        #1;
        check_all(tag);
        @(posedge clk);
        #1;
        free = D - mq.size();
        if (mq.size() != 0 && r) void'(mq.pop_front());
        for (int k = 0; k < 4; k++) begin
            if (v[k]) begin
                if (free > 0) begin
                    mq.push_back(d[k*W +: W]);
                    free--;
                end else begin
                    movf = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        cv = '0;
        rdy = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        mq.delete();
        movf = 1'b0;
    endtask

    logic [W-1:0]   a, b;
    logic [4*W-1:0] g;

    initial begin
        reset = 1'b1;
        cv = '0;
        cd = '0;
        rdy = 1'b0;

        // 1) reset and idle
        do_reset(2);
        cycle("idle", 4'b0000, '0, 1'b0);

        // 2) sparse lanes pack in order
        a = rnd_rec();
        b = rnd_rec();
        g = '0;
        g[1*W +: W] = a;
        g[3*W +: W] = b;
        cycle("sparse", 4'b1010, g, 1'b0);
        chk("sparse.headA", upd_data_o, a);
        cycle("hold", 4'b0000, '0, 1'b0);
        cycle("drainA", 4'b0000, '0, 1'b1);
        chk("sparse.headB", upd_data_o, b);
        cycle("drainB", 4'b0000, '0, 1'b1);
        cycle("empty", 4'b0000, '0, 1'b0);

        // 3) fill to full, stall release threshold
        repeat (4) cycle("fill", 4'b1111, rnd_grp(), 1'b0);
        chk("full.count", W'(count_o), W'(16));
        repeat (3) cycle("drain3", 4'b0000, '0, 1'b1);
        chk("c13.stall", W'(stall_o), W'(1));
        cycle("drain4", 4'b0000, '0, 1'b1);
        chk("c12.stall", W'(stall_o), W'(0));
        repeat (12) cycle("flush", 4'b0000, '0, 1'b1);

        // 4) move pointers to 14, then wrap
        repeat (3) cycle("adv", 4'b1111, rnd_grp(), 1'b0);
        repeat (12) cycle("advd", 4'b0000, '0, 1'b1);
        cycle("wrap", 4'b1111, rnd_grp(), 1'b0);
        cycle("c5", 4'b0001, rnd_grp(), 1'b0);
        cycle("enq2deq1", 4'b0011, rnd_grp(), 1'b1);
        chk("enq2deq1.count", W'(count_o), W'(6));
        repeat (6) cycle("wrapd", 4'b0000, '0, 1'b1);

        // 5) overflow on a protocol violation
        repeat (3) cycle("f14", 4'b1111, rnd_grp(), 1'b0);
        cycle("f14b", 4'b0011, rnd_grp(), 1'b0);
        cycle("viol", 4'b0111, rnd_grp(), 1'b0);
        chk("viol.ovf", W'(overflow_o), W'(1));
        chk("viol.count", W'(count_o), W'(16));
        repeat (7) cycle("to9", 4'b0000, '0, 1'b1);
        chk("sticky.ovf", W'(overflow_o), W'(1));

        // 6) reset mid-operation
        rdy = 1'b1;
        do_reset(1);
        cycle("postrst", 4'b0000, '0, 1'b1);
        a = rnd_rec();
        g = '0;
        g[2*W +: W] = a;
        cycle("first", 4'b0100, g, 1'b0);
        chk("first.data", upd_data_o, a);
        cycle("firstd", 4'b0000, '0, 1'b1);

        // Random traffic, occasional protocol violations and resets
        for (int i = 0; i < 600; i++) begin
            logic [3:0] v;
            v = 4'($urandom);
            if (stall_o && ($urandom_range(0, 7) != 0)) v = '0;
            if ($urandom_range(0, 149) == 0) begin
                do_reset(1);
            end else begin
                cycle("rnd", v, rnd_grp(), 1'($urandom_range(0, 2) != 0));
            end
        end
        cycle("end", 4'b0000, '0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
